pfb_weight_fold: RTL and testbench

Polyphase-filter-bank windowed fold stage, sitting directly downstream of the 4096x14 two-port weight RAM and upstream of the FFT.
- Drives the weight RAM read port and multiplies each incoming ADC sample by its window weight.
- Accumulates the NTAPS tap products per bin in an internal accumulator memory.
- Emits one folded NFFT-point frame per NTAPS*NFFT input samples (non-overlapped fold).

---
 rtl/pfb_pkg.sv | 40 ++++
 rtl/pfb_weight_fold_acc_ram.sv | 36 +++
 rtl/pfb_weight_fold.sv | 170 +++++++++++++++++
 tb/tb_pfb_weight_fold.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_pkg.sv
// rtl/pfb_pkg.sv - shared constants, helper function and datapath subtypes for the PFB fold stage
package pfb_pkg;

    // Constants:
    //   NFFT    bins per output frame
    //   NTAPS   taps folded per bin
    //   DW, WW  sample and weight widths (signed)
    //   AW      weight RAM address width, NFFT*NTAPS == 2**AW
    //   RAM_LAT weight RAM read latency in clocks
    localparam int NFFT    = 1024;
    localparam int NTAPS   = 4;
    localparam int DW      = 14;
    localparam int WW      = 14;
    localparam int AW      = 12;
    localparam int RAM_LAT = 2;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int NB = clog2(NFFT);    // bin index width
    localparam int TB = clog2(NTAPS);   // tap index width
    localparam int PW = DW + WW;        // full-precision product width
    localparam int OW = PW + TB;        // accumulator / output width

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [WW-1:0] weight_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [OW-1:0] acc_t;
    typedef logic        [AW-1:0] addr_t;
    typedef logic        [NB-1:0] bin_t;
    typedef logic        [TB-1:0] tap_t;

endpackage

// File: rtl/pfb_weight_fold_acc_ram.sv
// rtl/pfb_weight_fold_acc_ram.sv - simple dual-port accumulator RAM with 1-cycle registered read
//
// Ports:
//   clk_i    system clock (shared by both ports)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled every clock
//   rdata_o  registered read data, valid one clock after raddr_i
//
// No reset: contents are don't-care until the first tap of a frame overwrites them.
module pfb_acc_ram
    import pfb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 30,
    parameter int AWID  = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AWID-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AWID-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/pfb_weight_fold.sv
// rtl/pfb_weight_fold.sv - polyphase filter bank window-multiply and tap fold stage
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   enable               low holds the block idle and aborts any partial frame
//   in_data/in_valid     signed ADC sample and qualifier (no backpressure)
//   in_first             with in_valid: sample is frame index k=0
//   wr_addr/wr_data      weight RAM read address out, read data in (RAM_LAT later)
//   out_data/out_valid   folded bin value and qualifier
//   out_first/out_bin    bin-0 marker and bin index of out_data
//   frame_err            one-clock pulse when a partial frame is abandoned
//
// Pipeline (edges relative to the accepting edge E0):
//   E0                stage 0: wr_addr=k, sample captured
//   E1..E(RAM_LAT)    sample/index delay line, aligned with wr_data at the end
//   E(RAM_LAT+1)      product registered, acc[n] read issued in parallel
//   E(RAM_LAT+2)      accumulate: acc[n] written, last-tap sum captured
//   E(RAM_LAT+3)      output registers
module pfb_weight_fold
    import pfb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_first,
    output logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    output logic          out_first,
    output logic [NB-1:0] out_bin,
    output logic          frame_err
);

    // Frame counter and its next state.
    addr_t   k_q, k_d;
    addr_t   k_cur;

    // Stage 0 plus RAM_LAT delay stages; index RAM_LAT lines up with wr_data.
    logic    v_q [0:RAM_LAT];
    addr_t   a_q [0:RAM_LAT];
    sample_t x_q [0:RAM_LAT];

    // Multiply stage.
    logic    pv_q;
    addr_t   pa_q;
    prod_t   prod_q;

    // Accumulate stage.
    logic    sv_q;
    bin_t    sn_q;
    acc_t    sum_q;
    acc_t    sum_d;
    acc_t    acc_rd;
    acc_t    acc_base;

    // Output registers.
    logic    out_valid_q;
    logic    out_first_q;
    acc_t    out_data_q;
    bin_t    out_bin_q;
    logic    frame_err_q, frame_err_d;

    logic    accept;
    logic    realign;
    logic    flush;
    logic    first_tap;
    logic    last_tap;
    logic    acc_we;

    assign accept  = enable & in_valid;
    // in_first on a non-zero k abandons the current frame.
    assign realign = accept & in_first & (k_q != '0);
    // Anything already in flight belongs to an abandoned frame: drop it.
    assign flush   = ~enable | realign;

    assign k_cur = in_first ? addr_t'(0) : k_q;

    always_comb begin
        k_d         = k_q;
        frame_err_d = 1'b0;
        if (!enable) begin
            k_d         = '0;
            frame_err_d = (k_q != '0);
        end else if (accept) begin
            k_d         = k_cur + addr_t'(1);
            frame_err_d = realign;
        end
    end

    assign first_tap = (pa_q[AW-1:NB] == tap_t'(0));
    assign last_tap  = (pa_q[AW-1:NB] == tap_t'(NTAPS - 1));

    // Tap 0 starts a fresh sum, so stale accumulator contents never leak in.
    assign acc_base = first_tap ? acc_t'(0) : acc_rd;
    assign sum_d    = acc_base + acc_t'(prod_q);
    assign acc_we   = pv_q & ~last_tap & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q         <= '0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
            end
            pv_q        <= 1'b0;
            sv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_data_q  <= '0;
            out_bin_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            k_q         <= k_d;
            frame_err_q <= frame_err_d;

            // Stage 0: the realigning sample itself survives the flush.
            v_q[0] <= accept;
            if (accept) begin
                a_q[0] <= k_cur;
                x_q[0] <= in_data;
            end

            for (int i = 1; i <= RAM_LAT; i++) begin
                v_q[i] <= v_q[i-1] & ~flush;
                a_q[i] <= a_q[i-1];
                x_q[i] <= x_q[i-1];
            end

            pv_q   <= v_q[RAM_LAT] & ~flush;
            pa_q   <= a_q[RAM_LAT];
            prod_q <= prod_t'(x_q[RAM_LAT]) * prod_t'($signed(wr_data));

            sv_q   <= pv_q & last_tap & ~flush;
            sn_q   <= pa_q[NB-1:0];
            sum_q  <= sum_d;

            out_valid_q <= sv_q & ~flush;
            out_first_q <= sv_q & ~flush & (sn_q == '0);
            if (sv_q) begin
                out_data_q <= sum_q;
                out_bin_q  <= sn_q;
            end
        end
    end

    // Read of acc[n] is issued alongside the multiply so the data is ready
    // for the accumulate stage; the same n recurs only NFFT samples later.
    pfb_acc_ram #(
        .DEPTH (NFFT),
        .WIDTH (OW)
    ) u_acc_ram (
        .clk_i   (clk),
        .we_i    (acc_we),
        .waddr_i (pa_q[NB-1:0]),
        .wdata_i (sum_d),
        .raddr_i (a_q[RAM_LAT][NB-1:0]),
        .rdata_o (acc_rd)
    );

    assign wr_addr   = a_q[0];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_bin   = out_bin_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pfb_weight_fold.sv
// tb/tb_pfb_weight_fold.sv - scoreboard bench for the PFB weight fold stage
module tb_pfb_weight_fold;
    import pfb_pkg::*;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          enable   = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_first;
    logic [NB-1:0] out_bin;
    logic          frame_err;

    pfb_weight_fold dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_bin   (out_bin),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Edge counter: after the Nth rising edge, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight RAM model with RAM_LAT=2 registered read.
    int            wmem [NFFT*NTAPS];
    logic [WW-1:0] r1 = '0;
    logic [WW-1:0] r2 = '0;
    always @(posedge clk) begin
        r1 <= WW'(wmem[wr_addr]);
        r2 <= r1;
    end
    assign wr_data = r2;

    typedef struct {
        longint val;
        int     bin;
        int     due;
    } exp_t;

    exp_t   sb [$];
    int     err_q [$];
    int     n_cmp = 0;
    int     n_bad = 0;

    int     mk = 0;
    longint accm [NFFT];
    bit     use_const = 1'b0;
    longint const_val = 0;
    int     xmode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    exp_t e;
    bit   ee;
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: out_valid=1 bin=%0d, expected no output (cycle %0d)", out_bin, cyc);
            end else begin
                e = sb.pop_front();
                chk("out_data", longint'($signed(out_data)), e.val);
                chk("out_bin", longint'(out_bin), longint'(e.bin));
                chk("out_first", longint'(out_first), longint'(e.bin == 0));
                chk("latency_cycle", longint'(cyc), longint'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_out: bin %0d got no out_valid, expected at cycle %0d", e.bin, e.due);
        end
        ee = (err_q.size() > 0 && err_q[0] == cyc);
        if (ee) void'(err_q.pop_front());
        if (ee || frame_err) chk("frame_err", longint'(frame_err), longint'(ee));
    end

    // Drop every expectation that would have appeared on or after edge a.
    task automatic kill(input int a);
        while (sb.size() > 0 && sb[sb.size()-1].due >= a) void'(sb.pop_back());
    endtask

    function automatic int xval(input int idx);
        case (xmode)
            0:       return 100;
            1:       return (idx % 5) - 2;
            default: return -8192;
        endcase
    endfunction

    task automatic set_w(input int mode);
        for (int i = 0; i < NFFT*NTAPS; i++) begin
            case (mode)
                0:       wmem[i] = 1;
                1:       wmem[i] = (i % 7) - 3;
                default: wmem[i] = -8192;
            endcase
        end
    endtask

    task automatic send(input bit first);
        int     a;
        int     x;
        int     t;
        int     n;
        longint p;
        exp_t   ex;
        a = cyc + 1;
        if (first) begin
            if (mk != 0) begin
                err_q.push_back(a);
                kill(a);
            end
            mk = 0;
        end
        x        = xval(mk);
        in_valid = 1'b1;
        in_first = first;
        in_data  = DW'(x);
        t = mk / NFFT;
        n = mk % NFFT;
        p = longint'(wmem[mk]) * longint'(x);
        if (t == 0) accm[n] = p;
        else        accm[n] = accm[n] + p;
        if (t == NTAPS - 1) begin
            ex.val = use_const ? const_val : accm[n];
            ex.bin = n;
            ex.due = a + RAM_LAT + 3;
            sb.push_back(ex);
        end
        mk = (mk + 1) % (NFFT*NTAPS);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_enable(input int n);
        int a;
        enable = 1'b0;
        a = cyc + 1;
        if (mk != 0) err_q.push_back(a);
        kill(a);
        mk = 0;
        @(posedge clk);
        #1;
        chk("enable_drop_out_valid", longint'(out_valid), 0);
        idle(n);
        enable = 1'b1;
    endtask

    task automatic do_reset(input int n);
        int a;
        reset = 1'b1;
        a = cyc + 1;
        kill(a);
        mk = 0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        set_w(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_addr", longint'(wr_addr), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_first", longint'(out_first), 0);
        chk("reset_out_bin", longint'(out_bin), 0);
        chk("reset_frame_err", longint'(frame_err), 0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(2);

        // Unit weights, constant sample: every bin is 4*100.
        xmode = 0; use_const = 1'b1; const_val = 400;
        repeat (NFFT*NTAPS) send(1'b0);
        idle(8);

        // Patterned weights and samples, back to back.
        set_w(1); xmode = 1; use_const = 1'b0;
        repeat (NFFT*NTAPS) send(1'b0);
        idle(8);

        // Same pattern with random valid gaps.
        for (int i = 0; i < NFFT*NTAPS; i++) begin
            send(1'b0);
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) idle(1);
        end
        idle(8);

        // Realign mid-frame at k=1500, then a full frame from the new k=0.
        repeat (1500) send(1'b0);
        send(1'b1);
        repeat (NFFT*NTAPS - 1) send(1'b0);
        idle(8);

        // Full-scale negative weights and samples: 4 * 2**26.
        set_w(2); xmode = 2; use_const = 1'b1; const_val = 268435456;
        repeat (NFFT*NTAPS) send(1'b0);
        idle(8);

        // Enable drop during tap 3, then a clean frame.
        set_w(1); xmode = 1; use_const = 1'b0;
        repeat (3100) send(1'b0);
        drop_enable(3);
        repeat (NFFT*NTAPS) send(1'b0);
        idle(8);

        // Reset during tap 3, then a clean frame.
        repeat (3100) send(1'b0);
        do_reset(2);
        repeat (NFFT*NTAPS) send(1'b0);
        idle(12);

        chk("scoreboard_drained", longint'(sb.size()), 0);
        chk("frame_err_drained", longint'(err_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
